skid_pipeline: RTL and testbench
================================

# skid_pipeline

Parametrised chain of full skid-buffer stages on a valid/ready stream. It replaces the single backward skid buffer where long routes need several register slices. Every stage registers valid, data and ready, so no combinational path crosses the block in either direction. Sustained throughput is one beat per cycle, capacity is 2×DEPTH beats, and the block adds an occupancy count and a synchronous flush.

## Interface
- L, 8, payload width in bits (≥1)
- DEPTH, 2, number of skid stages in series (≥1)
- CW, $clog2(2*DEPTH+1), width of `count` (derived, not overridden)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; synchronous and active-low
- flush  in  1  synchronous clear, active-high, lower priority than rst
- valid_f  in  1  upstream beat valid
- data_f  in  L  upstream payload
- ready_f  out  1  upstream ready (registered)
- valid_b  out  1  downstream beat valid (registered)
- data_b  out  L  downstream payload (registered)
- ready_b  in  1  downstream ready
- count  out  CW  beats currently held, 0..2*DEPTH

## Operation
- Handshakes:
  - An upstream transfer occurs in any cycle with valid_f && ready_f.
  - A downstream transfer occurs in any cycle with valid_b && ready_b.
  - Beats leave in acceptance order. None are dropped or duplicated, except by flush or rst.
- Each stage k (0 = input side, DEPTH-1 = output side) has a main register, a skid register and a registered ready_k.
  - The stage's input handshake is valid_(k-1)/ready_k.
  - The stage's output handshake is main_valid_k / ready_(k+1), with ready_b used for the last stage.
- Stage states:
  - EMPTY: ready_k=1.
    - Input beat → load main, go to BUSY.
  - BUSY: ready_k=1.
    - in && out_rdy → main<=in, stay.
    - in && !out_rdy → skid<=in, go to FULL.
    - !in && out_rdy → go to EMPTY.
    - else hold.
  - FULL: ready_k=0.
    - out_rdy → main<=skid, go to BUSY.
    - else hold.
    - No input is accepted while FULL.
- ready_f = ready_0, valid_b = main_valid_(DEPTH-1), data_b = main_data_(DEPTH-1).
- While valid_b=1 && ready_b=0, data_b and valid_b hold stable.
- count:
  - +1 on an upstream transfer, −1 on a downstream transfer.
  - Unchanged when both or neither occur.
  - Never exceeds 2*DEPTH and never wraps.
- flush=1 at a clock edge:
  - All stages go to EMPTY, valid_b=0, count=0, and all ready_k=1 after the edge.
  - An upstream or downstream handshake in the flush cycle is discarded and does not count.
- rst=0 at a clock edge:
  - All stages go to EMPTY, valid_b=0, data_b=0, count=0, all ready_k=0.
  - The first edge with rst=1 sets ready_k=1.
  - rst overrides flush and any handshake.

## Timing
- Reset values: ready_f=0, valid_b=0, data_b=0, count=0.
  - ready_f rises after the first edge with rst=1, so the earliest upstream transfer is in the second cycle after release.
- Latency: a beat accepted in cycle c appears on valid_b/data_b in cycle c+DEPTH, provided the path is empty and ready_b=1.
- ready_f depends only on stage-0 state. It falls the cycle after stage 0 enters FULL and rises the cycle after stage 0 drains its skid.
- Backpressure:
  - With ready_b held 0 and valid_f held 1, exactly 2*DEPTH beats are accepted, then ready_f=0 and count=2*DEPTH.
- Release from full:
  - After ready_b returns to 1, valid_b stays 1 and one beat leaves per cycle until the block is empty.
- Simultaneous push and pop at count=2*DEPTH cannot occur, because ready_f=0.
- Simultaneous push and pop at any other count keeps count unchanged.

## Test plan
- Reset (L=8, DEPTH=3):
  - Hold rst=0 for 3 cycles with valid_f=1, data_f=0xAA → ready_f=0, valid_b=0, data_b=0x00, count=0 throughout.
  - ready_f=1 one cycle after release.
- Latency (DEPTH=3, ready_b=1):
  - Single beat 0x5C accepted in cycle c → valid_b=1, data_b=0x5C in cycle c+3 only.
  - count reads 1 from cycle c+1 through c+3, then 0.
- Streaming (ready_b=1):
  - Push 0x01..0x20 on consecutive cycles → 32 beats out in order on 32 consecutive cycles, with no ready_f deassertion.
- Backpressure fill/drain (DEPTH=3):
  - ready_b=0, continuous valid_f with incrementing data → exactly 6 beats accepted, then ready_f=0 and count=6.
  - Set ready_b=1 → 0x00..0x05 out in order, count steps 6→0, and ready_f returns to 1.
- Random stall:
  - 1000 beats with random valid_f and ready_b (50%) → scoreboard matches order and content.
  - data_b stable whenever valid_b && !ready_b.
  - count equals pushes minus pops every cycle.
- Flush / reset mid-operation:
  - With count=4, assert flush for one cycle alongside a push → next cycle valid_b=0, count=0, ready_f=1, and the pushed beat never appears.
  - Repeat with rst=0 instead → ready_f=0 for one cycle after release, then normal operation.

Source files
------------

// File: rtl/skid_pipeline_if.sv
`default_nettype none
// ============================================================================
//  Module      : skid_pipeline_if
//  Description : valid/ready stream bundle with producer (master) and
//                consumer (slave) views.
//  Revision    : 1.0  initial release
// ============================================================================
interface skid_pipeline_if #(
   parameter int L = 8
) ();
   logic         valid;
   logic [L-1:0] data;
   logic         ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/skid_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : skid_pipeline
//  Description : DEPTH full skid-buffer stages in series with occupancy
//                count and synchronous flush; every path is registered.
//  Revision    : 1.0  initial release
// ============================================================================
module skid_pipeline #(
   parameter int  L     = 8,
   parameter int  DEPTH = 2,
   localparam int CW    = $clog2(2*DEPTH+1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_flush,
   skid_pipeline_if.slave  i_up,
   skid_pipeline_if.master o_dn,
   output logic [CW-1:0]   o_count
);

   localparam logic [1:0] c_EMPTY = 2'd0;
   localparam logic [1:0] c_BUSY  = 2'd1;
   localparam logic [1:0] c_FULL  = 2'd2;

   // Chain index k is the input of stage k; index DEPTH is the block output.
   logic [DEPTH:0]        w_cv;
   logic [DEPTH:0][L-1:0] w_cd;
   logic [DEPTH:0]        w_cr;
   logic                  w_push;
   logic                  w_pop;
   logic [CW-1:0]         r_count;

   assign w_cv[0]     = i_up.valid;
   assign w_cd[0]     = i_up.data;
   assign i_up.ready  = w_cr[0];
   assign w_cr[DEPTH] = o_dn.ready;
   assign o_dn.valid  = w_cv[DEPTH];
   assign o_dn.data   = w_cd[DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [1:0]   r_state;
      logic [1:0]   w_nxt;
      logic [L-1:0] r_main;
      logic [L-1:0] r_skid;
      logic         r_rdy;
      logic         w_in_fire;
      logic         w_out_rdy;
      logic         w_ld_main;
      logic         w_ld_skid;
      logic [L-1:0] w_main_d;

      assign w_in_fire    = w_cv[gi] & r_rdy;
      assign w_out_rdy    = w_cr[gi+1];
      assign w_cv[gi+1]   = (r_state != c_EMPTY);
      assign w_cd[gi+1]   = r_main;
      assign w_cr[gi]     = r_rdy;

      always_comb begin
         w_nxt     = r_state;
         w_ld_main = 1'b0;
         w_ld_skid = 1'b0;
         w_main_d  = w_cd[gi];
         case (r_state)
            c_EMPTY: begin
               if (w_in_fire) begin
                  w_ld_main = 1'b1;
                  w_nxt     = c_BUSY;
               end
            end
            c_BUSY: begin
               if (w_in_fire && w_out_rdy) begin
                  w_ld_main = 1'b1;
               end else if (w_in_fire) begin
                  w_ld_skid = 1'b1;
                  w_nxt     = c_FULL;
               end else if (w_out_rdy) begin
                  w_nxt     = c_EMPTY;
               end
            end
            c_FULL: begin
               if (w_out_rdy) begin
                  w_ld_main = 1'b1;
                  w_main_d  = r_skid;
                  w_nxt     = c_BUSY;
               end
            end
            default: w_nxt = c_EMPTY;
         endcase
      end

      // Ready is registered from the next state so it is valid the cycle
      // the stage enters or leaves FULL, with no combinational ready path.
      always_ff @(posedge clk) begin
         if (!rst) begin
            r_state <= c_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_rdy   <= 1'b0;
         end else if (i_flush) begin
            r_state <= c_EMPTY;
            r_rdy   <= 1'b1;
         end else begin
            r_state <= w_nxt;
            r_rdy   <= (w_nxt != c_FULL);
            if (w_ld_main) r_main <= w_main_d;
            if (w_ld_skid) r_skid <= w_cd[gi];
         end
      end
   end

   assign w_push = w_cv[0] & w_cr[0];
   assign w_pop  = w_cv[DEPTH] & w_cr[DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_flush) begin
         r_count <= '0;
      end else if (w_push && !w_pop) begin
         r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_skid_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_skid_pipeline
//  Description : directed and random-stall checks of skid_pipeline (L=8, DEPTH=3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_skid_pipeline;
   localparam int L     = 8;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(2*DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [CW-1:0] count;
   int            n_tests = 0;
   int            n_fail  = 0;

   skid_pipeline_if #(.L(L)) up_if ();
   skid_pipeline_if #(.L(L)) dn_if ();

   skid_pipeline #(.L(L), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_up    (up_if),
      .o_dn    (dn_if),
      .o_count (count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Stimulus only: pushes n beats with ready_b=0, ends at the negedge after the last push.
   task automatic fill_to(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         dn_if.ready = 1'b0;
         up_if.valid = 1'b1;
         up_if.data  = base + 8'(i);
      end
      @(negedge clk);
      up_if.valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0;
      up_if.valid = 1'b1; up_if.data = 8'hAA; dn_if.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_f: got %b required 0", up_if.ready); end
         n_tests++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %b required 0", dn_if.valid); end
         n_tests++; if (dn_if.data !== 8'h00) begin n_fail++; $display("FAIL reset_data_b: got %h required 00", dn_if.data); end
         n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
      end
      rst = 1'b1; up_if.valid = 1'b0;
      @(negedge clk);
      n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_f: got %b required 1", up_if.ready); end
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL release_count: got %0d required 0", count); end
   endtask

   task automatic test_latency();
      @(negedge clk);
      dn_if.ready = 1'b1; up_if.valid = 1'b1; up_if.data = 8'h5C;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         up_if.valid = 1'b0;
         n_tests++;
         if (dn_if.valid !== (k == 3)) begin n_fail++; $display("FAIL latency_valid_b c+%0d: got %b required %b", k, dn_if.valid, (k == 3)); end
         if (k == 3) begin
            n_tests++; if (dn_if.data !== 8'h5C) begin n_fail++; $display("FAIL latency_data_b: got %h required 5c", dn_if.data); end
         end
         n_tests++;
         if (count !== ((k <= 3) ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL latency_count c+%0d: got %0d required %0d", k, count, (k <= 3) ? 1 : 0); end
      end
   endtask

   task automatic test_streaming();
      logic exp_v;
      dn_if.ready = 1'b1;
      for (int i = 0; i <= 35; i++) begin
         @(negedge clk);
         exp_v = (i >= 3) && (i <= 34);
         n_tests++; if (dn_if.valid !== exp_v) begin n_fail++; $display("FAIL stream_valid_b i=%0d: got %b required %b", i, dn_if.valid, exp_v); end
         if (exp_v) begin
            n_tests++; if (dn_if.data !== 8'(i - 2)) begin n_fail++; $display("FAIL stream_data_b i=%0d: got %h required %h", i, dn_if.data, 8'(i - 2)); end
         end
         if (i < 32) begin
            n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_f i=%0d: got %b required 1", i, up_if.ready); end
            up_if.valid = 1'b1; up_if.data = 8'(i + 1);
         end else begin
            up_if.valid = 1'b0;
         end
      end
   endtask

   task automatic test_backpressure();
      int acc;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         dn_if.ready = 1'b0; up_if.valid = 1'b1; up_if.data = 8'(acc);
         if (up_if.ready === 1'b1) acc++;
      end
      @(negedge clk);
      up_if.valid = 1'b0;
      n_tests++; if (acc != 6) begin n_fail++; $display("FAIL bp_accepted: got %0d required 6", acc); end
      n_tests++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_f: got %b required 0", up_if.ready); end
      n_tests++; if (count !== 3'd6) begin n_fail++; $display("FAIL bp_count_full: got %0d required 6", count); end
      dn_if.ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         n_tests++; if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid_b i=%0d: got %b required 1", i, dn_if.valid); end
         n_tests++; if (dn_if.data !== 8'(i)) begin n_fail++; $display("FAIL drain_data_b i=%0d: got %h required %h", i, dn_if.data, 8'(i)); end
         n_tests++; if (count !== 3'(6 - i)) begin n_fail++; $display("FAIL drain_count i=%0d: got %0d required %0d", i, count, 6 - i); end
      end
      @(negedge clk);
      n_tests++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid_b: got %b required 0", dn_if.valid); end
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_empty_count: got %0d required 0", count); end
      n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_f: got %b required 1", up_if.ready); end
   endtask

   task automatic test_random_stall();
      logic [7:0] q[$];
      logic [7:0] exp_d;
      logic [7:0] held_d;
      logic       held;
      logic       push;
      logic       pop;
      int         pushes;
      int         cyc;
      held = 1'b0; held_d = '0; pushes = 0; cyc = 0;
      while (cyc < 6000 && (pushes < 1000 || q.size() != 0)) begin
         @(negedge clk);
         cyc++;
         n_tests++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rand_count cyc=%0d: got %0d required %0d", cyc, count, q.size()); end
         if (held) begin
            n_tests++;
            if (dn_if.valid !== 1'b1 || dn_if.data !== held_d) begin
               n_fail++; $display("FAIL rand_stable cyc=%0d: got v=%b d=%h required v=1 d=%h", cyc, dn_if.valid, dn_if.data, held_d);
            end
         end
         up_if.valid = (pushes < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         up_if.data  = 8'($urandom);
         dn_if.ready = (pushes < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
         push = up_if.valid && up_if.ready;
         pop  = dn_if.valid && dn_if.ready;
         if (pop) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rand_order cyc=%0d: got beat %h required none", cyc, dn_if.data);
            end else begin
               exp_d = q.pop_front();
               if (dn_if.data !== exp_d) begin n_fail++; $display("FAIL rand_order cyc=%0d: got %h required %h", cyc, dn_if.data, exp_d); end
            end
         end
         if (push) begin
            q.push_back(up_if.data);
            pushes++;
         end
         held   = dn_if.valid && !dn_if.ready;
         held_d = dn_if.data;
      end
      @(negedge clk);
      n_tests++; if (pushes != 1000 || q.size() != 0) begin n_fail++; $display("FAIL rand_complete: got pushes=%0d left=%0d required 1000/0", pushes, q.size()); end
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rand_final_count: got %0d required 0", count); end
   endtask

   task automatic test_flush();
      fill_to(4, 8'h10);
      n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL flush_pre_count: got %0d required 4", count); end
      flush = 1'b1; up_if.valid = 1'b1; up_if.data = 8'hEE; dn_if.ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; up_if.valid = 1'b0;
      n_tests++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_b: got %b required 0", dn_if.valid); end
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d required 0", count); end
      n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_f: got %b required 1", up_if.ready); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost i=%0d: got valid_b=%b data=%h required 0", i, dn_if.valid, dn_if.data); end
      end
      up_if.valid = 1'b1; up_if.data = 8'h77;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         up_if.valid = 1'b0;
      end
      n_tests++; if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h77) begin n_fail++; $display("FAIL flush_after: got v=%b d=%h required v=1 d=77", dn_if.valid, dn_if.data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      fill_to(4, 8'h20);
      n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d required 4", count); end
      rst = 1'b0; up_if.valid = 1'b1; up_if.data = 8'hEE; dn_if.ready = 1'b1;
      @(negedge clk);
      rst = 1'b1; up_if.valid = 1'b0;
      n_tests++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_f: got %b required 0", up_if.ready); end
      n_tests++; if (dn_if.valid !== 1'b0 || dn_if.data !== 8'h00) begin n_fail++; $display("FAIL rstmid_out: got v=%b d=%h required v=0 d=00", dn_if.valid, dn_if.data); end
      n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d required 0", count); end
      @(negedge clk);
      n_tests++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_release_ready_f: got %b required 1", up_if.ready); end
      up_if.valid = 1'b1; up_if.data = 8'h99;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         up_if.valid = 1'b0;
         if (k < 3) begin
            n_tests++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost k=%0d: got %b required 0", k, dn_if.valid); end
         end
      end
      n_tests++; if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h99) begin n_fail++; $display("FAIL rstmid_after: got v=%b d=%h required v=1 d=99", dn_if.valid, dn_if.data); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_streaming();
      test_backpressure();
      test_random_stall();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
